pool_out_buffer: RTL
====================

Name: pool_out_buffer

Overview:
- Sits directly downstream of the max-pooling stage and its pooling control logic.
- Captures each pooled result as a single-cycle valid pulse and tags it with its output row, column, row-end and frame-end position.
- Holds results in a small FIFO and presents them to the writeback/next layer over a valid/ready interface.
- Decouples the fixed-rate pooling pipeline from a back-pressuring consumer and reports loss when that decoupling is exceeded.

Parameters:
- N, 16: pooled data width in bits.
- M, 4: input feature-map side length. Must be a multiple of P.
- P, 2: pooling window side. The output map side is Q = M/P.
- DEPTH, 8: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- master_rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous flush: empties the FIFO and zeroes the position counters
- in_valid  in  1  one pooled result present this cycle (no ready; the producer cannot stall)
- in_data  in  N  pooled result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head when out_valid is also high
- out_data  out  N  head data
- out_row_end  out  1  head is the last column of an output row
- out_last  out  1  head is the final element of the frame (row Q-1, column Q-1)
- fill  out  clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one input was dropped
- frame_done  out  1  one-cycle pulse registered after the out_last element is accepted

Behaviour:
- Reset (async, master_rst=1):
  - Pointers, fill, write-side column/row counters, overflow and frame_done all go to 0.
  - out_valid=0. out_data, out_row_end and out_last read as 0.
  - Memory contents are don't-care.
- Write side:
  - A push occurs when in_valid=1 and either fill<DEPTH, or fill==DEPTH while a pop occurs in the same cycle.
  - Each entry stores {last, row_end, data}, N+2 bits.
  - The tags come from write-side counters wcol and wrow, each 0..Q-1:
    - row_end = (wcol==Q-1)
    - last = row_end && (wrow==Q-1)
  - Counters advance only on an accepted push. wcol wraps to 0 and increments wrow. wrow wraps to 0 after the last element, ready for the next frame.
- Drop:
  - in_valid=1 with fill==DEPTH and no pop: data is discarded, overflow is set and counters do not advance.
  - overflow clears only on master_rst or clear.
- Read side (first-word fall-through):
  - out_valid = (fill!=0).
  - out_data and the tags are driven from the entry at the read pointer.
  - A pop occurs when out_valid && out_ready.
  - Latency from accepted push to out_valid is exactly 1 clock. There is no combinational in-to-out path.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and the tags hold stable.
  - out_ready while empty has no effect.
- Simultaneous push and pop: fill is unchanged and both pointers advance. This is legal at fill==DEPTH (the full case above) and at fill==1.
- Pointers are log2(DEPTH) bits and wrap naturally. fill is tracked explicitly with one extra bit.
- frame_done goes high the clock after a pop whose last tag is 1, for one cycle.
- clear has priority over push and pop in the same cycle:
  - fill=0, pointers=0, wcol=wrow=0, overflow=0.
  - in_valid in that cycle is ignored.
- Reset asserted mid-frame: everything reverts to reset values asynchronously. Output tags restart from (0,0) on the next push.

Decomposition:
- Shared package pool_pkg:
  - localparams Q = M/P and FRAME_LEN = Q*Q
  - PTR_W = clog2(DEPTH)
  - packed entry typedef {last, row_end, data[N-1:0]}
- One natural sub-module, sync_fifo_fwft (parameters W and DEPTH). It owns the memory, pointers, fill and the full/empty push/pop rules.
- The top level holds the position counters, drop/overflow logic and frame_done.

Test Plan:
- Defaults (M=4, P=2, DEPTH=8), out_ready=1: push 4 values 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles.
  - Each appears on out_data 1 cycle after its push.
  - out_row_end=1 on 0x0022 and 0x0044; out_last=1 on 0x0044.
  - frame_done pulses one cycle after 0x0044 is popped.
- Back-pressure: out_ready=0, push 8 values.
  - fill=8 and overflow=0.
  - A 9th push is dropped and overflow=1.
  - Then out_ready=1: the 8 original values drain in order and the 9th never appears.
- Full with concurrent pop: fill=8, in_valid=1 and out_ready=1 in the same cycle.
  - The push is accepted, fill stays at 8 and overflow stays 0.
- Wrap: stream 3 frames (12 pushes) with out_ready toggling 1,0,1,0.
  - Pointers wrap.
  - out_last is 1 only on elements 4, 8 and 12.
  - out_data stays stable during every ready=0 cycle.
- clear mid-frame after 2 pushes (fill=2):
  - Next cycle out_valid=0 and fill=0.
  - The next push is tagged row 0, column 0: row_end=0, last=0.
- Async master_rst pulse between clock edges with fill=5 and overflow=1:
  - out_valid, fill and overflow go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_pkg: shared geometry constants and entry layout for the pooled  |
// | output buffer.                                  Revision: 1.0        |
// +----------------------------------------------------------------------+
package pool_pkg;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_M     = 4;
  localparam int unsigned DEF_P     = 2;
  localparam int unsigned DEF_DEPTH = 8;

  localparam int unsigned Q         = DEF_M / DEF_P;
  localparam int unsigned FRAME_LEN = Q * Q;
  localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic              last;
    logic              row_end;
    logic [DEF_N-1:0]  data;
  } entry_t;

  function automatic int unsigned side_len(input int unsigned m, input int unsigned p);
    return m / p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft: first-word fall-through FIFO; a pop is allowed to    |
// | free the slot a same-cycle push needs when full.  Revision: 1.0      |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic                       o_push_ok,
  output logic                       o_pop_ok
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FILL_W-1:0] r_fill;

  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_fill == FILL_W'(DEPTH));
  assign w_pop_ok  = !i_clear && i_pop && (r_fill != '0);
  assign w_push_ok = !i_clear && i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage is not reset; the read port is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  assign o_valid   = (r_fill != '0);
  assign o_rdata   = o_valid ? r_mem[r_rptr] : '0;
  assign o_fill    = r_fill;
  assign o_push_ok = w_push_ok;
  assign o_pop_ok  = w_pop_ok;

endmodule
`default_nettype wire

// File: rtl/pool_out_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_out_buffer: tags pooled results with row/frame position and     |
// | buffers them for a back-pressuring consumer.     Revision: 1.0       |
// +----------------------------------------------------------------------+
module pool_out_buffer
  import pool_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned M     = DEF_M,
  parameter int unsigned P     = DEF_P,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   master_rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic                   out_row_end,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int unsigned QS = side_len(M, P);
  localparam int unsigned CW = (QS > 1) ? $clog2(QS) : 1;

  logic [CW-1:0] r_wcol;
  logic [CW-1:0] r_wrow;
  logic          r_overflow;
  logic          r_frame_done;

  logic          w_row_end;
  logic          w_last;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [N+1:0]  w_entry;
  logic [N+1:0]  w_head;

  assign w_row_end = (r_wcol == CW'(QS - 1));
  assign w_last    = w_row_end && (r_wrow == CW'(QS - 1));
  assign w_entry   = {w_last, w_row_end, in_data};

  sync_fifo_fwft #(
    .W     (N + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (master_rst),
    .i_clear   (clear),
    .i_push    (in_valid),
    .i_pop     (out_ready),
    .i_wdata   (w_entry),
    .o_rdata   (w_head),
    .o_valid   (out_valid),
    .o_fill    (fill),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok)
  );

  // Position only advances on stored results so dropped inputs leave no gap.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_wcol <= '0;
      r_wrow <= '0;
    end else if (clear) begin
      r_wcol <= '0;
      r_wrow <= '0;
    end else if (w_push_ok) begin
      if (w_row_end) begin
        r_wcol <= '0;
        r_wrow <= w_last ? '0 : r_wrow + CW'(1);
      end else begin
        r_wcol <= r_wcol + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (clear)                        r_overflow <= 1'b0;
      else if (in_valid && !w_push_ok)  r_overflow <= 1'b1;
      r_frame_done <= w_pop_ok && w_head[N+1];
    end
  end

  assign out_data    = w_head[N-1:0];
  assign out_row_end = w_head[N];
  assign out_last    = w_head[N+1];
  assign overflow    = r_overflow;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
